// File: rtl/param_universal_shift_register.sv
// Universal shift register: load, logical/arithmetic shifts and rotates,
// issued as single steps or as counted bursts with a busy/done handshake.
module param_universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [2:0]       op_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             sin_i,
  input  logic [WIDTH-1:0] i_i,
  output logic [WIDTH-1:0] q_o,
  output logic             sout_o,
  output logic             busy_o,
  output logic             done_o
);

  // state | meaning
  // IDLE  | accepts start (burst) or en (single step); start wins
  // BURST | applies latched op once per edge until rem reaches zero

  localparam logic [2:0] OP_HOLD0 = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_ROL   = 3'b100;
  localparam logic [2:0] OP_ROR   = 3'b101;
  localparam logic [2:0] OP_ASR   = 3'b110;
  localparam logic [2:0] OP_HOLD7 = 3'b111;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] rem_q;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             busy_q, done_q;
  logic [2:0]       step_op;
  logic             step_en;
  logic             burst_noop;

  // During a burst the latched op drives the datapath; op_i is don't-care.
  assign step_op    = (state_q == BURST) ? op_q : op_i;
  assign step_en    = (state_q == BURST) || (!start_i && en_i);
  assign burst_noop = (cnt_i == '0) || (op_i == OP_LOAD) ||
                      (op_i == OP_HOLD0) || (op_i == OP_HOLD7);

  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    case (step_op)
      OP_LOAD: q_d = i_i;
      OP_SHL: begin
        q_d    = {q_q[WIDTH-2:0], sin_i};
        sout_d = q_q[WIDTH-1];
      end
      OP_SHR: begin
        q_d    = {sin_i, q_q[WIDTH-1:1]};
        sout_d = q_q[0];
      end
      OP_ROL: begin
        q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        sout_d = q_q[WIDTH-1];
      end
      OP_ROR: begin
        q_d    = {q_q[0], q_q[WIDTH-1:1]};
        sout_d = q_q[0];
      end
      OP_ASR: begin
        q_d    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        sout_d = q_q[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= OP_HOLD0;
      rem_q   <= '0;
      q_q     <= '0;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (step_en) begin
        q_q    <= q_d;
        sout_q <= sout_d;
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            op_q  <= op_i;
            rem_q <= cnt_i;
            if (burst_noop) begin
              done_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              state_q <= BURST;
            end
          end
        end
        BURST: begin
          rem_q <= rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign q_o    = q_q;
  assign sout_o = sout_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_param_universal_shift_register.sv
// Directed bench for param_universal_shift_register (WIDTH=8, CNT_W=3):
// a single-step vector table followed by hand-written burst sequences.
module tb_param_universal_shift_register;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       en_i;
  logic [2:0] op_i;
  logic       start_i;
  logic [2:0] cnt_i;
  logic       sin_i;
  logic [7:0] i_i;
  logic [7:0] q_o;
  logic       sout_o, busy_o, done_o;

  int n_chk  = 0;
  int n_pass = 0;

  param_universal_shift_register #(.WIDTH(8), .CNT_W(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .op_i(op_i),
    .start_i(start_i), .cnt_i(cnt_i), .sin_i(sin_i), .i_i(i_i),
    .q_o(q_o), .sout_o(sout_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       en;
    logic [2:0] op;
    logic       sin;
    logic [7:0] d;
    logic [7:0] q;
    logic       sout;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    en_i = 1'b0; start_i = 1'b0; op_i = 3'b000; cnt_i = 3'd0;
    sin_i = 1'b0; i_i = 8'h00;
  endtask

  task automatic load(input logic [7:0] v);
    en_i = 1'b1; op_i = 3'b001; i_i = v;
    cyc();
    en_i = 1'b0;
  endtask

  task automatic start_burst(input logic [2:0] op, input logic [2:0] n);
    start_i = 1'b1; op_i = op; cnt_i = n;
    cyc();
    start_i = 1'b0; op_i = 3'b000; cnt_i = 3'd0;
  endtask

  initial begin
    int busy_cnt, done_cnt;
    logic [7:0] ror_exp[3];
    logic       ror_sout[3];

    vecs[0]  = '{1'b1, 3'b001, 1'b0, 8'hA5, 8'hA5, 1'b0};
    vecs[1]  = '{1'b1, 3'b010, 1'b1, 8'h00, 8'h4B, 1'b1};
    vecs[2]  = '{1'b1, 3'b011, 1'b0, 8'h00, 8'h25, 1'b1};
    vecs[3]  = '{1'b1, 3'b100, 1'b0, 8'h00, 8'h4A, 1'b0};
    vecs[4]  = '{1'b1, 3'b101, 1'b0, 8'h00, 8'h25, 1'b0};
    vecs[5]  = '{1'b1, 3'b110, 1'b0, 8'h00, 8'h12, 1'b1};
    vecs[6]  = '{1'b1, 3'b000, 1'b1, 8'hFF, 8'h12, 1'b1};
    vecs[7]  = '{1'b1, 3'b111, 1'b1, 8'hFF, 8'h12, 1'b1};
    vecs[8]  = '{1'b1, 3'b001, 1'b0, 8'h80, 8'h80, 1'b1};
    vecs[9]  = '{1'b1, 3'b110, 1'b0, 8'h00, 8'hC0, 1'b0};
    vecs[10] = '{1'b1, 3'b011, 1'b1, 8'h00, 8'hE0, 1'b0};
    vecs[11] = '{1'b0, 3'b001, 1'b1, 8'hFF, 8'hE0, 1'b0};
    vecs[12] = '{1'b1, 3'b010, 1'b0, 8'h00, 8'hC0, 1'b1};
    vecs[13] = '{1'b1, 3'b100, 1'b0, 8'h00, 8'h81, 1'b1};
    vecs[14] = '{1'b1, 3'b101, 1'b0, 8'h00, 8'hC0, 1'b1};

    ror_exp  = '{8'hD2, 8'h69, 8'hB4};
    ror_sout = '{1'b1, 1'b0, 1'b1};

    idle_inputs();
    rst_ni = 1'b0;
    #2;
    chk("reset_q", q_o, 8'h00);
    chk("reset_sout", sout_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int k = 0; k < 15; k++) begin
      en_i = vecs[k].en; op_i = vecs[k].op; sin_i = vecs[k].sin; i_i = vecs[k].d;
      cyc();
      chk($sformatf("vec%0d_q", k), q_o, vecs[k].q);
      chk($sformatf("vec%0d_sout", k), sout_o, vecs[k].sout);
      chk($sformatf("vec%0d_busy", k), busy_o, 0);
      chk($sformatf("vec%0d_done", k), done_o, 0);
    end
    idle_inputs();

    // ROR burst of 3 from 0xA5
    load(8'hA5);
    start_burst(3'b101, 3'd3);
    chk("ror_e0_busy", busy_o, 1);
    chk("ror_e0_q", q_o, 8'hA5);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("ror_step%0d_q", k), q_o, ror_exp[k]);
      chk($sformatf("ror_step%0d_sout", k), sout_o, ror_sout[k]);
      chk($sformatf("ror_step%0d_busy", k), busy_o, (k < 2) ? 1 : 0);
      chk($sformatf("ror_step%0d_done", k), done_o, (k == 2) ? 1 : 0);
    end
    cyc();
    chk("ror_done_drop", done_o, 0);
    chk("ror_q_hold", q_o, 8'hB4);

    // ASR burst of 7 from 0x80
    load(8'h80);
    start_burst(3'b110, 3'd7);
    busy_cnt = 1; done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (busy_o) busy_cnt++;
      if (done_o) done_cnt++;
    end
    chk("asr_q", q_o, 8'hFF);
    chk("asr_busy_cycles", busy_cnt, 7);
    chk("asr_done_pulses", done_cnt, 1);

    // en/start pulses during a SHL burst are ignored
    load(8'h3C);
    start_burst(3'b010, 3'd4);
    en_i = 1'b1; start_i = 1'b1; op_i = 3'b001; i_i = 8'h00; cnt_i = 3'd1;
    cyc();
    cyc();
    idle_inputs();
    cyc();
    chk("ign_busy_last", busy_o, 1);
    cyc();
    chk("ign_q", q_o, 8'hC0);
    chk("ign_sout", sout_o, 1);
    chk("ign_done", done_o, 1);
    chk("ign_busy_end", busy_o, 0);

    // zero-count and LOAD bursts: done pulse only
    start_burst(3'b010, 3'd0);
    chk("cnt0_done", done_o, 1);
    chk("cnt0_busy", busy_o, 0);
    chk("cnt0_q", q_o, 8'hC0);
    cyc();
    chk("cnt0_done_drop", done_o, 0);
    i_i = 8'h11;
    start_burst(3'b001, 3'd5);
    chk("loadburst_done", done_o, 1);
    chk("loadburst_busy", busy_o, 0);
    chk("loadburst_q", q_o, 8'hC0);

    // back-to-back: new start accepted in the done cycle
    start_burst(3'b100, 3'd1);
    cyc();
    chk("b2b_first_q", q_o, 8'h81);
    chk("b2b_first_done", done_o, 1);
    start_burst(3'b101, 3'd1);
    chk("b2b_second_busy", busy_o, 1);
    chk("b2b_second_done", done_o, 0);
    cyc();
    chk("b2b_second_q", q_o, 8'hC0);
    chk("b2b_second_doneb", done_o, 1);
    cyc();

    // reset after 2 of 5 ROL steps
    load(8'h81);
    start_burst(3'b100, 3'd5);
    cyc();
    cyc();
    chk("rst_mid_q_before", q_o, 8'h06);
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_mid_q", q_o, 8'h00);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_sout", sout_o, 0);
    chk("rst_mid_done", done_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    done_cnt = 0; busy_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (done_o) done_cnt++;
      if (busy_o) busy_cnt++;
    end
    chk("rst_after_done", done_cnt, 0);
    chk("rst_after_busy", busy_cnt, 0);
    chk("rst_after_q", q_o, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
